// File: rtl/dm_access_arbiter.sv
// Data-memory access arbiter between the CPU MEM stage and an external port.
// Define DM_ARB_ALIGN_CHK_EN to suppress misaligned writes and pulse err.
module dm_access_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rd,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wd,
  input  logic [3:0]  ext_be,
  output logic [31:0] ext_rd,
  output logic        ext_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rd,
  output logic        err
);

  // state   | meaning
  // IDLE    | arbitrate and latch the winner's request
  // CPU_ACC | memory cycles on behalf of the CPU port
  // EXT_ACC | memory cycles on behalf of the external port
  typedef enum logic [1:0] {IDLE, CPU_ACC, EXT_ACC} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE = 4'(STARVE_LIM);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic        we_q;
  logic [31:0] addr_q, wd_q;
  logic [3:0]  be_q;
  logic        grant_ext, grant_cpu, final_cyc, wr_block;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wd;
  logic [3:0]  sel_be;

  assign grant_ext = ext_req & (~cpu_req | (wait_cnt == STARVE));
  assign grant_cpu = cpu_req & ~grant_ext;
  assign final_cyc = (state != IDLE) && (cnt == 4'd0);

  assign sel_we   = grant_ext ? ext_we   : cpu_we;
  assign sel_addr = grant_ext ? ext_addr : cpu_addr;
  assign sel_wd   = grant_ext ? ext_wd   : cpu_wd;
  assign sel_be   = grant_ext ? ext_be   : cpu_be;

  // Memory is word addressed; the byte offset only matters to the alignment check.
  assign mem_addr  = addr_q & 32'hFFFF_FFFC;
  assign mem_wd    = wd_q;
  assign mem_be    = be_q;
  assign cpu_rd    = mem_rd;
  assign ext_rd    = mem_rd;
  assign cpu_stall = cpu_req & ~cpu_done;

`ifdef DM_ARB_ALIGN_CHK_EN
  logic mis_q;
  logic sel_mis;

  assign sel_mis = ((sel_be == 4'b1111) && (sel_addr[1:0] != 2'b00)) ||
                   (((sel_be == 4'b0011) || (sel_be == 4'b1100)) && sel_addr[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if ((state == IDLE) && (grant_cpu || grant_ext)) begin
      mis_q <= sel_mis;
    end
  end

  assign wr_block = mis_q;
  assign err      = final_cyc & mis_q;
`else
  assign wr_block = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wd_q     <= 32'd0;
      be_q     <= 4'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_nxt;
      if ((state == IDLE) && (grant_cpu || grant_ext)) begin
        we_q   <= sel_we;
        addr_q <= sel_addr;
        wd_q   <= sel_wd;
        be_q   <= sel_be;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wait_nxt  = wait_cnt;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_done  = 1'b0;
    ext_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ext) begin
          state_nxt = EXT_ACC;
          cnt_nxt   = LAT_M1;
          wait_nxt  = 4'd0;
        end else if (grant_cpu) begin
          state_nxt = CPU_ACC;
          cnt_nxt   = LAT_M1;
          if (ext_req && (wait_cnt != STARVE)) begin
            wait_nxt = wait_cnt + 4'd1;
          end
        end
      end
      CPU_ACC, EXT_ACC: begin
        mem_en = 1'b1;
        if (cnt == 4'd0) begin
          mem_we    = we_q & ~wr_block;
          cpu_done  = (state == CPU_ACC);
          ext_ack   = (state == EXT_ACC);
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A withdrawn external request forfeits any accumulated priority.
    if (!ext_req) begin
      wait_nxt = 4'd0;
    end
  end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
Arbitrates the single-ported data memory between the CPU MEM stage and an external requester (loader/debug port). Each requester presents an already-formatted word-aligned write word plus byte enables. The block sequences one access at a time with a fixed, parameterised memory latency. It stalls the CPU while an access is pending and prevents starvation of the external port.

Parameters:
MEM_LAT, 2, memory access cycles per transfer (1..15)
STARVE_LIM, 4, consecutive lost arbitrations after which ext wins (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held until cpu_done
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  32  byte address
cpu_wd  in  32  lane-positioned write data
cpu_be  in  4  byte enables
cpu_rd  out  32  read data, valid when cpu_done=1
cpu_done  out  1  access-complete strobe
cpu_stall  out  1  cpu_req & ~cpu_done
ext_req/ext_we/ext_addr/ext_wd/ext_be  in  1/1/32/32/4  external port, same semantics as the CPU port
ext_rd  out  32  read data, valid when ext_ack=1
ext_ack  out  1  access-complete strobe
mem_en  out  1  memory select
mem_we  out  1  memory write strobe
mem_addr  out  32  word address to memory; bits [1:0] forced to 0
mem_wd  out  32  write data
mem_be  out  4  byte enables
mem_rd  in  32  memory read data, valid in the final access cycle
err  out  1  alignment-error strobe (see Optional Feature)

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset: state=IDLE, cnt=0, wait_cnt=0, all registered mem_* = 0. cpu_done, ext_ack, err = 0.
- States:
  - IDLE: arbitrate on the sampled requests.
    - ext wins if ext_req & (~cpu_req | wait_cnt==STARVE_LIM).
    - Otherwise CPU wins if cpu_req.
    - Winner's we/addr/wd/be are latched into mem_* registers. cnt loads MEM_LAT-1. Next state is CPU_ACC or EXT_ACC.
  - CPU_ACC / EXT_ACC: mem_en=1 and address/data held stable every cycle. cnt decrements.
    - Final cycle (cnt==0): mem_we=latched we; done/ack asserted combinationally; rd = mem_rd passthrough. Next state is IDLE.
- mem_we is high only in the final access cycle, giving exactly one write per transfer.
- Per-access latency: request sampled in IDLE cycle N, access cycles N+1..N+MEM_LAT, done in cycle N+MEM_LAT, IDLE again at N+MEM_LAT+1. Throughput is one access per MEM_LAT+1 cycles.
- cpu_done/ext_ack are single-cycle. cpu_rd/ext_rd are don't-care outside done/ack.
- wait_cnt:
  - Increments, saturating at STARVE_LIM, on each IDLE cycle where the CPU is granted while ext_req=1.
  - Clears on an ext grant or when ext_req=0.
- Requester drops req mid-access: the access still completes. The done/ack strobe is emitted and ignored.
- Signals changing during the access have no effect; latched values are used.
- Neither request high in IDLE: remain in IDLE, mem_en=0, mem_we=0.
- Reset mid-access: immediate return to IDLE with outputs at reset values. No write occurs unless the final-cycle edge has already passed.

Optional Feature:
Macro DM_ARB_ALIGN_CHK_EN.
- With the macro, an access is misaligned if either:
  - be==4'b1111 and addr[1:0]!=0, or
  - be is 4'b0011/4'b1100 and addr[0]!=0.
- A misaligned access still runs its MEM_LAT cycles and done/ack strobes normally, but mem_we stays 0 and err pulses together with done/ack.
- Without the macro, no check is made and err is tied to 0.

Test Plan:
- MEM_LAT=2, CPU read addr 0x10, mem returns 0xDEADBEEF -> mem_en high cycles 1-2, mem_addr=0x10, cpu_done and cpu_rd=0xDEADBEEF in cycle 2, cpu_stall high cycles 0-1, IDLE cycle 3.
- CPU write addr 0x22, be=4'b0100, wd=0x00AB0000 -> mem_we high only in cycle 2 with mem_be=0100, mem_addr=0x20, mem_wd=0x00AB0000.
- cpu_req and ext_req rise in the same cycle -> CPU served first (done cycle 2), ext granted from IDLE cycle 3, ext_ack cycle 5.
- STARVE_LIM=3, cpu_req held high continuously, ext_req held high -> CPU wins 3 arbitrations, ext wins the 4th, wait_cnt then clears.
- rst_n pulled low in cycle 1 of a CPU write -> mem_we never asserted, all outputs 0, state IDLE after release.
- With DM_ARB_ALIGN_CHK_EN: CPU write be=4'b1111, addr 0x22 -> err=1 and cpu_done=1 in cycle 2, mem_we=0 throughout.
